// File: rtl/hazardctl_if.sv
// hazardctl_if: bundle between the LEGv8 pipeline datapath and the hazard
// sequencer.
//   i_* : hazard-detection inputs, driven by the pipeline (master)
//   o_* : hold enables, bubble controls, fault flag and stall counter,
//         driven by hazardctl (slave)
interface hazardctl_if #(
  parameter int CNTWIDTH = 32
);
  logic                i_idexmemread;
  logic [4:0]          i_idexrd;
  logic [4:0]          i_ifidrn;
  logic [4:0]          i_ifidrm;
  logic                i_ifidusesrm;
  logic                i_branchtaken;
  logic                i_dmemreq;
  logic                i_dmemready;
  logic                o_pcwrite;
  logic                o_ifidwrite;
  logic                o_idexwrite;
  logic                o_exmemwrite;
  logic                o_ifidnop;
  logic                o_idexnop;
  logic                o_exmemnop;
  logic                o_memwbnop;
  logic                o_memfault;
  logic [CNTWIDTH-1:0] o_stallcycles;

  modport master (
    output i_idexmemread, i_idexrd, i_ifidrn, i_ifidrm, i_ifidusesrm,
           i_branchtaken, i_dmemreq, i_dmemready,
    input  o_pcwrite, o_ifidwrite, o_idexwrite, o_exmemwrite,
           o_ifidnop, o_idexnop, o_exmemnop, o_memwbnop,
           o_memfault, o_stallcycles
  );

  modport slave (
    input  i_idexmemread, i_idexrd, i_ifidrn, i_ifidrm, i_ifidusesrm,
           i_branchtaken, i_dmemreq, i_dmemready,
    output o_pcwrite, o_ifidwrite, o_idexwrite, o_exmemwrite,
           o_ifidnop, o_idexnop, o_exmemnop, o_memwbnop,
           o_memfault, o_stallcycles
  );
endinterface

// File: rtl/hazardctl.sv
// hazardctl: hazard and stall sequencer for the five-stage LEGv8 pipeline.
// Resolves load-use stalls, taken-branch flushes (branch resolved in MEM)
// and data-memory waits with a timeout watchdog that freezes the core.
// Ports:
//   i_clk   : clock, rising edge
//   i_nrst  : asynchronous active-low reset
//   bus     : hazardctl_if slave modport (hazard inputs, pipeline controls,
//             sticky memory fault, saturating stall-cycle counter)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_RUN     | normal issue; memstall/branch/load-use handled by priority
// S_MEMWAIT | waiting on data memory, r_waitcnt = stall cycles seen so far
// S_FAULT   | memory timeout; pipeline frozen until reset
module hazardctl #(
  parameter int TIMEOUT  = 16,
  parameter int CNTWIDTH = 32
) (
  input logic  i_clk,
  input logic  i_nrst,
  hazardctl_if.slave bus
);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_FAULT} state_t;

  state_t              r_state;
  logic [WW-1:0]       r_waitcnt;
  logic                r_memfault;
  logic [CNTWIDTH-1:0] r_stallcycles;

  logic w_memstall;
  logic w_loaduse;
  logic w_pcwrite, w_ifidwrite, w_idexwrite, w_exmemwrite;
  logic w_ifidnop, w_idexnop, w_exmemnop, w_memwbnop;

  assign w_memstall = (r_state != S_FAULT) && bus.i_dmemreq && !bus.i_dmemready;

  // XZR reads as zero, so a load targeting X31 never feeds a consumer.
  assign w_loaduse = bus.i_idexmemread && (bus.i_idexrd != 5'd31) &&
                     ((bus.i_idexrd == bus.i_ifidrn) ||
                      (bus.i_ifidusesrm && (bus.i_idexrd == bus.i_ifidrm)));

  always_comb begin
    w_pcwrite    = 1'b1;
    w_ifidwrite  = 1'b1;
    w_idexwrite  = 1'b1;
    w_exmemwrite = 1'b1;
    w_ifidnop    = 1'b0;
    w_idexnop    = 1'b0;
    w_exmemnop   = 1'b0;
    w_memwbnop   = 1'b0;
    if (!i_nrst || r_state == S_FAULT) begin
      w_pcwrite    = 1'b0;
      w_ifidwrite  = 1'b0;
      w_idexwrite  = 1'b0;
      w_exmemwrite = 1'b0;
      w_ifidnop    = 1'b1;
      w_idexnop    = 1'b1;
      w_exmemnop   = 1'b1;
      w_memwbnop   = 1'b1;
    end else if (w_memstall) begin
      // Freeze everything up to MEM; bubble MEM/WB so the stalled
      // instruction is not written back twice.
      w_pcwrite    = 1'b0;
      w_ifidwrite  = 1'b0;
      w_idexwrite  = 1'b0;
      w_exmemwrite = 1'b0;
      w_memwbnop   = 1'b1;
    end else if (bus.i_branchtaken) begin
      // Squash the three younger instructions; the branch itself retires.
      w_ifidnop  = 1'b1;
      w_idexnop  = 1'b1;
      w_exmemnop = 1'b1;
    end else if (w_loaduse) begin
      w_pcwrite   = 1'b0;
      w_ifidwrite = 1'b0;
      w_idexnop   = 1'b1;
    end
  end

  assign bus.o_pcwrite     = w_pcwrite;
  assign bus.o_ifidwrite   = w_ifidwrite;
  assign bus.o_idexwrite   = w_idexwrite;
  assign bus.o_exmemwrite  = w_exmemwrite;
  assign bus.o_ifidnop     = w_ifidnop;
  assign bus.o_idexnop     = w_idexnop;
  assign bus.o_exmemnop    = w_exmemnop;
  assign bus.o_memwbnop    = w_memwbnop;
  assign bus.o_memfault    = r_memfault;
  assign bus.o_stallcycles = r_stallcycles;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state       <= S_RUN;
      r_waitcnt     <= '0;
      r_memfault    <= 1'b0;
      r_stallcycles <= '0;
    end else begin
      if (!w_pcwrite && (r_stallcycles != {CNTWIDTH{1'b1}}))
        r_stallcycles <= r_stallcycles + 1'b1;

      case (r_state)
        S_RUN: begin
          if (w_memstall) begin
            r_state   <= S_MEMWAIT;
            r_waitcnt <= WW'(1);
          end
        end
        S_MEMWAIT: begin
          // A dropped request is treated the same as a ready response.
          if (!bus.i_dmemreq || bus.i_dmemready) begin
            r_state   <= S_RUN;
            r_waitcnt <= '0;
          end else if (r_waitcnt == WW'(TIMEOUT - 1)) begin
            r_state    <= S_FAULT;
            r_memfault <= 1'b1;
          end else begin
            r_waitcnt <= r_waitcnt + 1'b1;
          end
        end
        S_FAULT: begin
          r_memfault <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazardctl.sv
module tb_hazardctl;
  // control vector order: pcwrite ifidwrite idexwrite exmemwrite
  //                       ifidnop idexnop exmemnop memwbnop
  localparam logic [7:0] DEF = 8'b1111_0000;
  localparam logic [7:0] LU  = 8'b0011_0100;
  localparam logic [7:0] BR  = 8'b1111_1110;
  localparam logic [7:0] MS  = 8'b0000_0001;
  localparam logic [7:0] FZ  = 8'b0000_1111;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic        mf;
    logic [31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] sc_m = '0;
  bit   drv_done = 1'b0;

  hazardctl_if #(.CNTWIDTH(32)) hif();

  hazardctl #(.TIMEOUT(4), .CNTWIDTH(32)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (hif)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic usesrm, input logic bt,
                        input logic req, input logic rdy);
    hif.i_idexmemread = mr;
    hif.i_idexrd      = rd;
    hif.i_ifidrn      = rn;
    hif.i_ifidrm      = rm;
    hif.i_ifidusesrm  = usesrm;
    hif.i_branchtaken = bt;
    hif.i_dmemreq     = req;
    hif.i_dmemready   = rdy;
  endtask

  // Push the expected response for the current cycle, then advance to just
  // after the next rising edge. Stall count is modelled from the expected
  // pcwrite, not read from the DUT.
  task automatic cyc(input string nm, input logic [7:0] c, input logic mf);
    exp_t e;
    if (!nrst) sc_m = '0;
    e.name = nm;
    e.ctl  = c;
    e.mf   = mf;
    e.sc   = sc_m;
    sb.push_back(e);
    if (nrst && !c[7]) sc_m = sc_m + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s %s: got %0h want %0h", nm, what, got, want);
  endtask

  // monitor: compare DUT outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = sb.pop_front();
      got = {hif.o_pcwrite, hif.o_ifidwrite, hif.o_idexwrite, hif.o_exmemwrite,
             hif.o_ifidnop, hif.o_idexnop, hif.o_exmemnop, hif.o_memwbnop};
      chk(e.name, "ctl", {24'd0, got}, {24'd0, e.ctl});
      chk(e.name, "memfault", {31'd0, hif.o_memfault}, {31'd0, e.mf});
      chk(e.name, "stallcycles", hif.o_stallcycles, e.sc);
    end
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset", FZ, 0);
    nrst = 1'b1;
    cyc("idle", DEF, 0);

    set_in(1, 3, 3, 0, 0, 0, 0, 0);  cyc("loaduse_rn", LU, 0);
    set_in(0, 3, 3, 0, 0, 0, 0, 0);  cyc("loaduse_clear", DEF, 0);
    set_in(1, 31, 31, 0, 0, 0, 0, 0); cyc("xzr", DEF, 0);
    set_in(1, 5, 0, 5, 0, 0, 0, 0);  cyc("rm_unused", DEF, 0);
    set_in(1, 5, 0, 5, 1, 0, 0, 0);  cyc("rm_used", LU, 0);
    set_in(0, 0, 0, 0, 0, 1, 0, 0);  cyc("branch", BR, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("branch_after", DEF, 0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("memwait1", MS, 0);
    cyc("memwait2", MS, 0);
    cyc("memwait3", MS, 0);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);  cyc("mem_release", DEF, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mem_after", DEF, 0);

    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    cyc("memwait_br1", MS, 0);
    cyc("memwait_br2", MS, 0);
    set_in(0, 0, 0, 0, 0, 1, 1, 1);  cyc("release_flush", BR, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("flush_after", DEF, 0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("to1", MS, 0);
    cyc("to2", MS, 0);
    cyc("to3", MS, 0);
    cyc("to4", MS, 0);
    cyc("fault", FZ, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);  cyc("fault_ready", FZ, 1);
    set_in(1, 3, 3, 0, 0, 1, 0, 0);  cyc("fault_sticky", FZ, 1);
    nrst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("fault_reset", FZ, 0);
    nrst = 1'b1;                      cyc("post_reset", DEF, 0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_a", MS, 0);
    cyc("mw_b", MS, 0);
    nrst = 1'b0;                      cyc("async_rst", FZ, 0);
    nrst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("async_after", DEF, 0);

    set_in(1, 3, 3, 0, 0, 1, 0, 0);  cyc("br_over_lu", BR, 0);
    set_in(1, 3, 3, 0, 0, 0, 0, 0);  cyc("lu_alone", LU, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("final_idle", DEF, 0);
    drv_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!(drv_done && sb.size() == 0) && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++;
      $display("FAIL timeout: got %0d pending want 0", sb.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazardctl.md
Name: hazardctl

Overview:
- Pipeline hazard and stall sequencer for the five-stage LEGv8 core.
- Drives hold enables and bubble-insert (nop) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes:
  - load-use hazards;
  - taken-branch flushes, with the branch resolved in MEM;
  - multi-cycle data-memory waits, with a watchdog that freezes the core on timeout.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
TIMEOUT, 16, max consecutive MEMWAIT cycles before fault (≥2)
CNTWIDTH, 32, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
idexmemread  in  1  instruction in EX is a load
idexrd  in  5  destination register of instruction in EX
ifidrn  in  5  first source register of instruction in ID
ifidrm  in  5  second source register of instruction in ID
ifidusesrm  in  1  instruction in ID reads rm
branchtaken  in  1  instruction in MEM is a taken branch
dmemreq  in  1  instruction in MEM accesses data memory
dmemready  in  1  data memory completes access this cycle
pcwrite  out  1  PC update enable
ifidwrite  out  1  IF/ID load enable
idexwrite  out  1  ID/EX load enable
exmemwrite  out  1  EX/MEM load enable
ifidnop  out  1  clear IF/ID control
idexnop  out  1  clear ID/EX control
exmemnop  out  1  clear EX/MEM control
memwbnop  out  1  clear MEM/WB control
memfault  out  1  sticky memory-timeout fault
stallcycles  out  CNTWIDTH  count of cycles with pcwrite=0

Behaviour:
- Reset (nrst=0, async):
  - State goes to RUN; wait counter = 0; memfault = 0; stallcycles = 0.
  - While nrst=0, all write enables are forced to 0 and all nop outputs to 1.
- Outputs are combinational from state and inputs; state, wait counter, memfault and stallcycles are registered.
- Default in RUN with no hazard: all write enables 1, all nops 0.
- memstall = dmemreq && !dmemready, evaluated in RUN or MEMWAIT.
- Priority, highest first: FAULT > memstall > branch flush > load-use.
- memstall cycle:
  - pcwrite = ifidwrite = idexwrite = exmemwrite = 0.
  - memwbnop = 1, so no duplicate writeback occurs.
  - All other nops = 0.
- Branch flush (branchtaken, no memstall):
  - All enables = 1.
  - ifidnop = idexnop = exmemnop = 1; memwbnop = 0.
  - PC loads the target; the branch itself proceeds to WB.
- Load-use condition: idexmemread && idexrd != 31 && (idexrd == ifidrn || (ifidusesrm && idexrd == ifidrm)).
  - X31 (XZR) never creates a hazard.
  - Response, when no higher-priority event: pcwrite = 0, ifidwrite = 0, idexnop = 1; other enables 1, other nops 0.
  - Exactly one bubble is inserted; the condition clears naturally next cycle.
- FSM:
  - RUN:
    - memstall → MEMWAIT, waitcnt = 1.
    - Otherwise stay in RUN.
  - MEMWAIT:
    - dmemready=1: release this cycle (normal RUN rules apply, including a pending branchtaken flush); → RUN, waitcnt = 0.
    - dmemready=0 and waitcnt == TIMEOUT-1: → FAULT.
    - Otherwise waitcnt += 1.
    - dmemreq dropping to 0 while in MEMWAIT is treated as release: → RUN.
  - FAULT:
    - All enables 0, all nops 1, memfault = 1.
    - Exits only via reset.
- Timeout counting: the first stall cycle is count 1. With TIMEOUT=16, 16 consecutive not-ready cycles lead to FAULT on the following edge.
- stallcycles:
  - Increments on every rising edge where pcwrite=0 and nrst=1, FAULT cycles included.
  - Saturates at 2^CNTWIDTH-1; no wrap.
- Simultaneous branchtaken and load-use: the branch flush wins, because the ID instruction is squashed anyway.
- Simultaneous branchtaken and memstall: freeze; the flush is applied on the release cycle.

Test Plan:
- Load-use: idexmemread=1, idexrd=3, ifidrn=3 → one cycle with pcwrite=0, ifidwrite=0, idexnop=1; stallcycles +1.
- XZR and rm gating:
  - idexmemread=1, idexrd=31, ifidrn=31 → no stall.
  - idexrd=5, ifidrm=5, ifidusesrm=0 → no stall; ifidusesrm=1 → stall.
- Branch: branchtaken=1 for one cycle → ifidnop = idexnop = exmemnop = 1, memwbnop = 0, pcwrite = 1; next cycle defaults.
- Memory wait: dmemreq=1, dmemready low for 3 cycles then high → 3 cycles frozen with memwbnop=1; release on 4th cycle; stallcycles +3.
- Timeout: TIMEOUT=4, dmemready held 0 → FAULT after 4 stall cycles; memfault=1 persists with dmemready=1; nrst pulse low clears it to RUN.
- Async reset mid-MEMWAIT: drop nrst between edges → outputs immediately forced (enables 0, nops 1), state RUN, stallcycles=0; priority check: branchtaken plus load-use in the same cycle → flush response, no load-use stall.
